// File: rtl/de1soc_pkg.sv
// Shared board constants for the DE1-SoC input conditioning path.
// Debounce window is derived from the board clock.
package de1soc_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 1;

  localparam int DEBOUNCE_CYCLES_DEFAULT =
    CLK_HZ / 1000 * DEBOUNCE_MS;

  localparam int NUM_SW   = 10;
  localparam int NUM_KEYS = 4;

endpackage

// File: rtl/de1soc_input_conditioner_debounce_bit.sv
// One-bit two-flop synchronizer plus debounce counter.
// Registered rise/fall pulses accompany each accepted level change.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        // mismatch held long enough: accept new level
        dout <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/de1soc_input_conditioner.sv
// Debounced switches and active-high keys with edge pulses.
// Replaces raw SW/KEY_N wiring into the core logic.
module de1soc_input_conditioner
  import de1soc_pkg::*;
#(
  parameter int NUM_SW          = de1soc_pkg::NUM_SW,
  parameter int NUM_KEYS        = de1soc_pkg::NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] KEY_N,
  output logic [NUM_SW-1:0]   sw_stable,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sw_changed
);

  logic [NUM_KEYS-1:0] key_act;
  logic [NUM_SW-1:0]   sw_rise;
  logic [NUM_SW-1:0]   sw_fall;

  assign key_act = ~KEY_N;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (SW[i]),
      .dout (sw_stable[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (key_act[i]),
      .dout (key_level[i]),
      .rise (key_press[i]),
      .fall (key_release[i])
    );
  end

  // OR of registered per-bit flags, no path from raw inputs
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_de1soc_input_conditioner.sv
// Directed and randomized bench for de1soc_input_conditioner.
// Reference: a level is accepted once D consecutive delayed samples agree.
`timescale 1ps/1ps
module tb_de1soc_input_conditioner;

  localparam int D  = 8;
  localparam int NS = 10;
  localparam int NK = 4;
  localparam int NB = NS + NK;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] sw;
  logic [NK-1:0] key_n;
  logic [NS-1:0] sw_stable;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          sw_changed;

  de1soc_input_conditioner #(
    .NUM_SW          (NS),
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SW          (sw),
    .KEY_N       (key_n),
    .sw_stable   (sw_stable),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .sw_changed  (sw_changed)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // history of raw input words {active keys, switches}, one per edge
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_stable = '0;
  logic [NB-1:0] m_rise   = '0;
  logic [NB-1:0] m_fall   = '0;

  int n_press;
  int n_rel;
  int n_chg;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // level accepted when the last D synchronized samples agree
  // and differ from the current level
  task automatic model_edge();
    int last;
    int base;
    logic v;
    bit same;
    m_rise = '0;
    m_fall = '0;
    if (rst) begin
      hist.delete();
      repeat (D + 2) hist.push_back('0);
      m_stable = '0;
    end else begin
      hist.push_back({~key_n, sw});
      while (hist.size() > D + 3) void'(hist.pop_front());
      last = hist.size() - 1;
      base = last - 2;
      for (int b = 0; b < NB; b++) begin
        v = hist[base][b];
        same = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist[base-k][b] != v) same = 1'b0;
        if (same && v != m_stable[b]) begin
          m_stable[b] = v;
          if (v) m_rise[b] = 1'b1;
          else   m_fall[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sw_stable",   16'(sw_stable),   16'(m_stable[NS-1:0]));
    chk("key_level",   16'(key_level),   16'(m_stable[NB-1:NS]));
    chk("key_press",   16'(key_press),   16'(m_rise[NB-1:NS]));
    chk("key_release", 16'(key_release), 16'(m_fall[NB-1:NS]));
    chk("sw_changed",  16'(sw_changed),
        16'(|(m_rise[NS-1:0] | m_fall[NS-1:0])));
    n_press += $countones(key_press);
    n_rel   += $countones(key_release);
    n_chg   += int'(sw_changed);
  endtask

  task automatic clr();
    n_press = 0;
    n_rel   = 0;
    n_chg   = 0;
  endtask

  logic [NS-1:0] sweep[$];
  int hold;

  initial begin
    rst   = 1'b1;
    sw    = '0;
    key_n = 4'b0111;
    clr();

    // reset with key 3 held
    repeat (5) cyc();
    chk("rst_level", 16'(key_level), 16'h0);
    chk("rst_sw", 16'(sw_stable), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (D + 1) cyc();
    chk("s1_early", 16'(key_level), 16'h0);
    cyc();
    chk("s1_level", 16'(key_level), 16'h8);
    chk("s1_press", 16'(key_press), 16'h8);
    key_n = 4'b1111;
    repeat (D + 4) cyc();

    // clean press and release on key 0
    clr();
    key_n[0] = 1'b0;
    repeat (40) cyc();
    chk("s2_presses", 16'(n_press), 16'd1);
    key_n[0] = 1'b1;
    repeat (D + 1) cyc();
    chk("s2_rel_early", 16'(n_rel), 16'd0);
    cyc();
    chk("s2_release", 16'(key_release), 16'h1);
    repeat (4) cyc();

    // bounce on key 1
    clr();
    for (int i = 0; i < 10; i++) begin
      key_n[1] = ~key_n[1];
      repeat (3) cyc();
    end
    chk("s3_bounce", 16'(n_press + n_rel), 16'd0);
    key_n[1] = 1'b0;
    repeat (D + 4) cyc();
    chk("s3_press", 16'(n_press), 16'd1);
    key_n[1] = 1'b1;
    repeat (D + 4) cyc();

    // switch sweep, shortened, including the 1023 -> 0 wrap
    clr();
    for (int v = 1; v < 16; v++) sweep.push_back(NS'(v));
    for (int v = 1020; v < 1024; v++) sweep.push_back(NS'(v));
    sweep.push_back('0);
    foreach (sweep[i]) begin
      sw = sweep[i];
      repeat (101) cyc();
      chk("s4_track", 16'(sw_stable), 16'(sweep[i]));
    end
    chk("s4_changes", 16'(n_chg), 16'(sweep.size()));

    // simultaneous key and switch events
    key_n = 4'b1000;
    sw    = 10'h2AA;
    repeat (D + 1) cyc();
    cyc();
    chk("s5_press", 16'(key_press), 16'h7);
    chk("s5_swchg", 16'(sw_changed), 16'h1);
    key_n = 4'b1111;
    repeat (D + 4) cyc();

    // reset with a count in progress
    clr();
    key_n[0] = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("s6_nopulse", 16'(n_press), 16'd0);
    repeat (D + 1) cyc();
    chk("s6_early", 16'(key_level), 16'h0);
    cyc();
    chk("s6_press", 16'(key_press), 16'h1);
    key_n = 4'b1111;
    repeat (D + 4) cyc();

    // randomized toggles with random hold lengths
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0)
        sw[$urandom_range(0, NS - 1)] ^= 1'b1;
      else
        key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
      rst  = ($urandom_range(0, 49) == 0);
      hold = $urandom_range(1, 2 * D);
      repeat (hold) begin
        cyc();
        rst = 1'b0;
      end
    end
    repeat (D + 4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
